dpd_poly_mac: RTL and testbench

- Downstream consumer of the magnitude-power stage (mag_0..mag_4, |x|^0..|x|^4).
- Forms memoryless polynomial predistortion y = sum_{k=0..4} c_k * x * |x|^k, with c_k complex coefficients.
- Coefficients are double-buffered (shadow/active) and loaded by a host write port.
- Output feeds the DAC interpolation path.

---
 rtl/dpd_poly_mac.sv | 236 +++++++++++++++++++++++
 tb/tb_dpd_poly_mac.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpd_poly_mac.sv
// Memoryless complex polynomial predistorter y = sum_{k=0..4} c_k * x * |x|^k with a
// double-buffered host coefficient bank and a latency-matched bypass path.
module dpd_poly_mac #(
  parameter int D_ALIGN = 16,
  parameter int CW      = 18
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [19:0]   sig_in_i,
  input  logic [19:0]   sig_in_q,
  input  logic          in_valid,
  input  logic [19:0]   mag_0,
  input  logic [19:0]   mag_1,
  input  logic [19:0]   mag_2,
  input  logic [19:0]   mag_3,
  input  logic [19:0]   mag_4,
  input  logic          coef_wr,
  input  logic [2:0]    coef_addr,
  input  logic [CW-1:0] coef_re,
  input  logic [CW-1:0] coef_im,
  input  logic          coef_commit,
  input  logic          bypass,
  output logic [19:0]   sig_out_i,
  output logic [19:0]   sig_out_q,
  output logic          out_valid,
  output logic          sat_flag,
  input  logic          sat_clr
);
  localparam int NT  = 5;
  localparam int PW  = 20 + CW;
  localparam int SW4 = PW + 1;
  localparam int SW5 = PW + 4;
  localparam int RW  = SW5 - 16;

  // Returns {clipped, value} for a signed value clamped to s20.
  function automatic logic [20:0] sat_s20(input logic signed [RW-1:0] v);
    logic [20:0] r;
    if (v > RW'(524287))       r = {1'b1, 20'h7FFFF};
    else if (v < RW'(-524288)) r = {1'b1, 20'h80000};
    else                       r = {1'b0, v[19:0]};
    return r;
  endfunction

  function automatic logic signed [RW-1:0] round_b(input logic signed [39:0] p);
    logic signed [21:0] r;
    logic unused_lsbs;
    unused_lsbs = ^p[17:0];
    r = $signed({p[39], p[39:19]}) + $signed({21'd0, p[18]});
    return RW'(r);
  endfunction

  function automatic logic signed [RW-1:0] round_o(input logic signed [SW5-1:0] s);
    logic signed [SW5-1:0] v;
    logic unused_lsbs;
    v = s + SW5'(32768);
    unused_lsbs = ^v[15:0];
    return v[SW5-1:16];
  endfunction

  logic [19:0] mag [NT];
  assign mag[0] = mag_0;
  assign mag[1] = mag_1;
  assign mag[2] = mag_2;
  assign mag[3] = mag_3;
  assign mag[4] = mag_4;

  logic [19:0]         dly_i_d [D_ALIGN], dly_i_q [D_ALIGN];
  logic [19:0]         dly_q_d [D_ALIGN], dly_q_q [D_ALIGN];
  logic [D_ALIGN-1:0]  dly_v_d, dly_v_q;

  logic signed [CW-1:0] sh_re_d [NT], sh_re_q [NT], sh_im_d [NT], sh_im_q [NT];
  logic signed [CW-1:0] act_re_d [NT], act_re_q [NT], act_im_d [NT], act_im_q [NT];

  logic signed [39:0]  s1_bre_d [NT], s1_bre_q [NT], s1_bim_d [NT], s1_bim_q [NT];
  logic signed [19:0]  s2_bre_d [NT], s2_bre_q [NT], s2_bim_d [NT], s2_bim_q [NT];
  logic signed [PW-1:0] s3_rr_d [NT], s3_rr_q [NT], s3_ii_d [NT], s3_ii_q [NT];
  logic signed [PW-1:0] s3_ri_d [NT], s3_ri_q [NT], s3_ir_d [NT], s3_ir_q [NT];
  logic signed [SW4-1:0] s4_re_d [NT], s4_re_q [NT], s4_im_d [NT], s4_im_q [NT];
  logic signed [SW5-1:0] s5_re_d, s5_re_q, s5_im_d, s5_im_q;

  // x, valid, bypass and S2-clip tags ride alongside the datapath, one entry per stage.
  logic [19:0] s1_xi_q, s1_xq_q, s2_xi_q, s2_xq_q, s3_xi_q, s3_xq_q;
  logic [19:0] s4_xi_q, s4_xq_q, s5_xi_q, s5_xq_q;
  logic        s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q, s5_vld_q;
  logic        s1_byp_q, s2_byp_q, s3_byp_q, s4_byp_q, s5_byp_q;
  logic        s2_clip_d, s2_clip_q, s3_clip_q, s4_clip_q, s5_clip_q;

  logic [19:0] out_i_d, out_i_q, out_q_d, out_q_q;
  logic        out_valid_q, sat_flag_d, sat_flag_q;

  always_comb begin
    dly_i_d[0] = sig_in_i;
    dly_q_d[0] = sig_in_q;
    for (int k = 1; k < D_ALIGN; k++) begin
      dly_i_d[k] = dly_i_q[k-1];
      dly_q_d[k] = dly_q_q[k-1];
    end
    dly_v_d = {dly_v_q[D_ALIGN-2:0], in_valid};
  end

  // A write in the commit cycle lands in shadow first, so the commit carries it.
  always_comb begin
    sh_re_d  = sh_re_q;
    sh_im_d  = sh_im_q;
    act_re_d = act_re_q;
    act_im_d = act_im_q;
    if (coef_wr && (coef_addr < 3'd5)) begin
      sh_re_d[coef_addr] = coef_re;
      sh_im_d[coef_addr] = coef_im;
    end
    if (coef_commit) begin
      act_re_d = sh_re_d;
      act_im_d = sh_im_d;
    end
  end

  always_comb begin
    logic [20:0] rs;
    s2_clip_d = 1'b0;
    for (int k = 0; k < NT; k++) begin
      s1_bre_d[k] = 40'($signed(dly_i_q[D_ALIGN-1])) * 40'($signed({1'b0, mag[k]}));
      s1_bim_d[k] = 40'($signed(dly_q_q[D_ALIGN-1])) * 40'($signed({1'b0, mag[k]}));
      rs = sat_s20(round_b(s1_bre_q[k]));
      s2_bre_d[k] = rs[19:0];
      s2_clip_d   = s2_clip_d | rs[20];
      rs = sat_s20(round_b(s1_bim_q[k]));
      s2_bim_d[k] = rs[19:0];
      s2_clip_d   = s2_clip_d | rs[20];
      s3_rr_d[k] = PW'(s2_bre_q[k]) * PW'(act_re_q[k]);
      s3_ii_d[k] = PW'(s2_bim_q[k]) * PW'(act_im_q[k]);
      s3_ri_d[k] = PW'(s2_bre_q[k]) * PW'(act_im_q[k]);
      s3_ir_d[k] = PW'(s2_bim_q[k]) * PW'(act_re_q[k]);
      s4_re_d[k] = SW4'(s3_rr_q[k]) - SW4'(s3_ii_q[k]);
      s4_im_d[k] = SW4'(s3_ri_q[k]) + SW4'(s3_ir_q[k]);
    end
    s2_clip_d = s2_clip_d & s1_vld_q & ~s1_byp_q;
    s5_re_d = '0;
    s5_im_d = '0;
    for (int k = 0; k < NT; k++) begin
      s5_re_d = s5_re_d + SW5'(s4_re_q[k]);
      s5_im_d = s5_im_d + SW5'(s4_im_q[k]);
    end
  end

  // Final rounding; set beats clear on the sticky flag, bypassed samples never set it.
  always_comb begin
    logic [20:0] ri, rq;
    ri = sat_s20(round_o(s5_re_q));
    rq = sat_s20(round_o(s5_im_q));
    out_i_d = s5_byp_q ? s5_xi_q : ri[19:0];
    out_q_d = s5_byp_q ? s5_xq_q : rq[19:0];
    sat_flag_d = (s5_vld_q & ~s5_byp_q & (ri[20] | rq[20] | s5_clip_q)) |
                 (sat_flag_q & ~sat_clr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < D_ALIGN; k++) begin
        dly_i_q[k] <= '0;
        dly_q_q[k] <= '0;
      end
      dly_v_q <= '0;
      for (int k = 0; k < NT; k++) begin
        sh_re_q[k]  <= '0;
        sh_im_q[k]  <= '0;
        act_re_q[k] <= '0;
        act_im_q[k] <= '0;
        s1_bre_q[k] <= '0;
        s1_bim_q[k] <= '0;
        s2_bre_q[k] <= '0;
        s2_bim_q[k] <= '0;
        s3_rr_q[k]  <= '0;
        s3_ii_q[k]  <= '0;
        s3_ri_q[k]  <= '0;
        s3_ir_q[k]  <= '0;
        s4_re_q[k]  <= '0;
        s4_im_q[k]  <= '0;
      end
      sh_re_q[0]  <= CW'(65536);
      act_re_q[0] <= CW'(65536);
      s5_re_q <= '0;
      s5_im_q <= '0;
      {s1_xi_q, s1_xq_q, s2_xi_q, s2_xq_q, s3_xi_q, s3_xq_q} <= '0;
      {s4_xi_q, s4_xq_q, s5_xi_q, s5_xq_q} <= '0;
      {s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q, s5_vld_q} <= '0;
      {s1_byp_q, s2_byp_q, s3_byp_q, s4_byp_q, s5_byp_q} <= '0;
      {s2_clip_q, s3_clip_q, s4_clip_q, s5_clip_q} <= '0;
      out_i_q     <= '0;
      out_q_q     <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
    end else begin
      dly_i_q  <= dly_i_d;
      dly_q_q  <= dly_q_d;
      dly_v_q  <= dly_v_d;
      sh_re_q  <= sh_re_d;
      sh_im_q  <= sh_im_d;
      act_re_q <= act_re_d;
      act_im_q <= act_im_d;
      s1_bre_q <= s1_bre_d;
      s1_bim_q <= s1_bim_d;
      s2_bre_q <= s2_bre_d;
      s2_bim_q <= s2_bim_d;
      s3_rr_q  <= s3_rr_d;
      s3_ii_q  <= s3_ii_d;
      s3_ri_q  <= s3_ri_d;
      s3_ir_q  <= s3_ir_d;
      s4_re_q  <= s4_re_d;
      s4_im_q  <= s4_im_d;
      s5_re_q  <= s5_re_d;
      s5_im_q  <= s5_im_d;
      s1_xi_q <= dly_i_q[D_ALIGN-1];
      s1_xq_q <= dly_q_q[D_ALIGN-1];
      {s2_xi_q, s2_xq_q} <= {s1_xi_q, s1_xq_q};
      {s3_xi_q, s3_xq_q} <= {s2_xi_q, s2_xq_q};
      {s4_xi_q, s4_xq_q} <= {s3_xi_q, s3_xq_q};
      {s5_xi_q, s5_xq_q} <= {s4_xi_q, s4_xq_q};
      {s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q, s5_vld_q} <=
        {dly_v_q[D_ALIGN-1], s1_vld_q, s2_vld_q, s3_vld_q, s4_vld_q};
      {s1_byp_q, s2_byp_q, s3_byp_q, s4_byp_q, s5_byp_q} <=
        {bypass, s1_byp_q, s2_byp_q, s3_byp_q, s4_byp_q};
      {s2_clip_q, s3_clip_q, s4_clip_q, s5_clip_q} <=
        {s2_clip_d, s2_clip_q, s3_clip_q, s4_clip_q};
      out_i_q     <= out_i_d;
      out_q_q     <= out_q_d;
      out_valid_q <= s5_vld_q;
      sat_flag_q  <= sat_flag_d;
    end
  end

  assign sig_out_i = out_i_q;
  assign sig_out_q = out_q_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_flag_q;

endmodule

// File: tb/tb_dpd_poly_mac.sv
// Directed bench for dpd_poly_mac: each scenario task drives a sample stream, logs outputs
// per cycle and checks hand-computed results at the fixed D_ALIGN+6 latency.
module tb_dpd_poly_mac;
  localparam int D   = 16;
  localparam int LAT = D + 6;
  localparam int NH  = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] sig_in_i, sig_in_q;
  logic        in_valid;
  logic [19:0] mag_0, mag_1, mag_2, mag_3, mag_4;
  logic        coef_wr;
  logic [2:0]  coef_addr;
  logic [17:0] coef_re, coef_im;
  logic        coef_commit, bypass, sat_clr;
  logic [19:0] sig_out_i, sig_out_q;
  logic        out_valid, sat_flag;

  int   oi_h [NH];
  int   oq_h [NH];
  logic ov_h [NH];
  logic sf_h [NH];
  int   m0_h [NH];
  int   m1_h [NH];
  logic byp_h [NH];
  int   cyc, n_cmp, n_bad;

  always #5 clk = ~clk;

  dpd_poly_mac #(.D_ALIGN(D), .CW(18)) dut (
    .clk(clk), .reset(reset),
    .sig_in_i(sig_in_i), .sig_in_q(sig_in_q), .in_valid(in_valid),
    .mag_0(mag_0), .mag_1(mag_1), .mag_2(mag_2), .mag_3(mag_3), .mag_4(mag_4),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_re(coef_re), .coef_im(coef_im),
    .coef_commit(coef_commit), .bypass(bypass),
    .sig_out_i(sig_out_i), .sig_out_q(sig_out_q), .out_valid(out_valid),
    .sat_flag(sat_flag), .sat_clr(sat_clr)
  );

  // One clock of stimulus: x now, mag/bypass for the sample issued D cycles earlier.
  task automatic step(input int xi, input int xq, input logic vld, input logic byp,
                      input int m0, input int m1);
    if (cyc >= NH) begin
      $display("[TB] FAIL history_bound cyc=%0d limit=%0d", cyc, NH);
      $fatal(1, "[TB] history overflow");
    end
    sig_in_i = 20'(xi);
    sig_in_q = 20'(xq);
    in_valid = vld;
    m0_h[cyc] = m0;
    m1_h[cyc] = m1;
    byp_h[cyc] = byp;
    if (cyc >= D) begin
      mag_0  = 20'(m0_h[cyc-D]);
      mag_1  = 20'(m1_h[cyc-D]);
      bypass = byp_h[cyc-D];
    end else begin
      mag_0  = '0;
      mag_1  = '0;
      bypass = 1'b0;
    end
    @(negedge clk);
    oi_h[cyc] = $signed(sig_out_i);
    oq_h[cyc] = $signed(sig_out_q);
    ov_h[cyc] = out_valid;
    sf_h[cyc] = sat_flag;
    cyc++;
    @(posedge clk);
    #1;
    coef_wr = 1'b0;
    coef_commit = 1'b0;
    sat_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic coef(input int addr, input int re, input int im, input logic commit);
    coef_wr = 1'b1;
    coef_addr = 3'(addr);
    coef_re = 18'(re);
    coef_im = 18'(im);
    coef_commit = commit;
    idle(1);
  endtask

  task automatic test_reset();
    int t0;
    n_cmp++;
    if (sig_out_i !== 20'd0 || sig_out_q !== 20'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_out got=(%0d,%0d) exp=(0,0)", sig_out_i, sig_out_q);
    end
    n_cmp++;
    if (out_valid !== 1'b0 || sat_flag !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL reset_flags got valid=%b sat=%b exp 0/0", out_valid, sat_flag);
    end
    reset = 1'b0;
    t0 = cyc;
    step(262144, -131072, 1'b1, 1'b0, 524287, 293085);
    idle(LAT + 1);
    n_cmp++;
    if (oi_h[t0+LAT] !== 262144 || oq_h[t0+LAT] !== -131072) begin
      n_bad++;
      $display("[TB] FAIL identity_out got=(%0d,%0d) exp=(262144,-131072)", oi_h[t0+LAT], oq_h[t0+LAT]);
    end
    n_cmp++;
    if (ov_h[t0+LAT] !== 1'b1 || ov_h[t0+LAT-1] !== 1'b0 || ov_h[t0+LAT+1] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL identity_latency got valid@L-1,L,L+1=%b%b%b exp=010",
               ov_h[t0+LAT-1], ov_h[t0+LAT], ov_h[t0+LAT+1]);
    end
    n_cmp++;
    if (sf_h[t0+LAT] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL identity_sat got=%b exp=0", sf_h[t0+LAT]);
    end
  endtask

  task automatic test_coef_swap();
    int t0, exp;
    coef(1, 65536, 0, 1'b0);
    coef(0, 0, 0, 1'b0);
    coef(5, 99999, 777, 1'b0);
    coef(7, 1234, 4321, 1'b0);
    t0 = cyc;
    for (int i = 0; i < 30; i++) begin
      if (i == 25) coef_commit = 1'b1;
      step(262144, 0, 1'b1, 1'b0, 524287, 262144);
    end
    idle(LAT + 1);
    for (int i = 0; i < 30; i++) begin
      exp = (i < 25 - D - 1) ? 262144 : 131072;
      n_cmp++;
      if (oi_h[t0+i+LAT] !== exp || oq_h[t0+i+LAT] !== 0 || ov_h[t0+i+LAT] !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL coef_swap[%0d] got=(%0d,%0d,v%b) exp=(%0d,0,v1)",
                 i, oi_h[t0+i+LAT], oq_h[t0+i+LAT], ov_h[t0+i+LAT], exp);
      end
    end
  endtask

  task automatic test_write_commit();
    int t0;
    coef(1, 0, 0, 1'b0);
    coef(0, 0, 65536, 1'b1);
    idle(2);
    t0 = cyc;
    step(100000, 0, 1'b1, 1'b0, 524287, 0);
    idle(LAT + 1);
    n_cmp++;
    if (oi_h[t0+LAT] !== 0 || oq_h[t0+LAT] !== 100000 || ov_h[t0+LAT] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL write_commit got=(%0d,%0d,v%b) exp=(0,100000,v1)",
               oi_h[t0+LAT], oq_h[t0+LAT], ov_h[t0+LAT]);
    end
    n_cmp++;
    if (sf_h[t0+LAT] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL write_commit_sat got=%b exp=0", sf_h[t0+LAT]);
    end
  endtask

  task automatic test_saturation();
    int t0;
    coef(0, 131071, 0, 1'b1);
    idle(2);
    t0 = cyc;
    for (int i = 0; i < 50; i++) begin
      if (i == 30 || i == 46) sat_clr = 1'b1;
      if (i < 20) step(500000, 500000, 1'b1, 1'b0, 524287, 0);
      else        step(0, 0, 1'b0, 1'b0, 0, 0);
    end
    for (int i = 0; i < 20; i++) begin
      n_cmp++;
      if (oi_h[t0+i+LAT] !== 524287 || oq_h[t0+i+LAT] !== 524287) begin
        n_bad++;
        $display("[TB] FAIL sat_out[%0d] got=(%0d,%0d) exp=(524287,524287)",
                 i, oi_h[t0+i+LAT], oq_h[t0+i+LAT]);
      end
    end
    n_cmp++;
    if (sf_h[t0+LAT-1] !== 1'b0 || sf_h[t0+LAT] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL sat_set got before/at=%b%b exp=01", sf_h[t0+LAT-1], sf_h[t0+LAT]);
    end
    n_cmp++;
    if (sf_h[t0+31] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL sat_set_wins got=%b exp=1", sf_h[t0+31]);
    end
    n_cmp++;
    if (sf_h[t0+45] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL sat_sticky got=%b exp=1", sf_h[t0+45]);
    end
    n_cmp++;
    if (sf_h[t0+47] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL sat_clear got=%b exp=0", sf_h[t0+47]);
    end
  endtask

  task automatic test_bypass_toggle();
    int t0, idx, ei, eq;
    logic byp;
    coef(0, 65536, 0, 1'b1);
    idle(2);
    t0 = cyc;
    for (int k = 1; k <= 24; k++) step(k, -k, 1'b1, (((k - 1) / 3) % 2) == 1, 262144, 0);
    idle(LAT + 1);
    for (int k = 1; k <= 24; k++) begin
      byp = (((k - 1) / 3) % 2) == 1;
      ei  = byp ? k : (k + 1) >> 1;
      eq  = byp ? -k : -(k >> 1);
      idx = t0 + k - 1 + LAT;
      n_cmp++;
      if (oi_h[idx] !== ei || oq_h[idx] !== eq || ov_h[idx] !== 1'b1) begin
        n_bad++;
        $display("[TB] FAIL bypass_ramp[%0d] got=(%0d,%0d,v%b) exp=(%0d,%0d,v1)",
                 k, oi_h[idx], oq_h[idx], ov_h[idx], ei, eq);
      end
    end
    n_cmp++;
    if (ov_h[t0+LAT-1] !== 1'b0 || ov_h[t0+24+LAT] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL bypass_frame got valid before/after=%b%b exp=00",
               ov_h[t0+LAT-1], ov_h[t0+24+LAT]);
    end
  endtask

  task automatic test_s2_clip();
    int t0, t1;
    t0 = cyc;
    step(524287, -524288, 1'b1, 1'b1, 1048575, 0);
    step(524287, -524288, 1'b1, 1'b0, 1048575, 0);
    idle(LAT + 2);
    n_cmp++;
    if (oi_h[t0+LAT] !== 524287 || oq_h[t0+LAT] !== -524288 || sf_h[t0+LAT] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL bypass_no_sat got=(%0d,%0d,s%b) exp=(524287,-524288,s0)",
               oi_h[t0+LAT], oq_h[t0+LAT], sf_h[t0+LAT]);
    end
    n_cmp++;
    if (oi_h[t0+LAT+1] !== 524287 || oq_h[t0+LAT+1] !== -524288 || sf_h[t0+LAT+1] !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL s2_clip got=(%0d,%0d,s%b) exp=(524287,-524288,s1)",
               oi_h[t0+LAT+1], oq_h[t0+LAT+1], sf_h[t0+LAT+1]);
    end
    sat_clr = 1'b1;
    idle(1);
    t1 = cyc;
    idle(1);
    n_cmp++;
    if (sf_h[t1] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL s2_clip_clear got=%b exp=0", sf_h[t1]);
    end
  endtask

  task automatic test_async_reset();
    int t0, t1;
    coef(0, 32768, 0, 1'b1);
    idle(2);
    for (int i = 0; i < 30; i++) step(5000, 0, 1'b1, 1'b0, 524287, 0);
    n_cmp++;
    if (ov_h[cyc-1] !== 1'b1 || oi_h[cyc-1] !== 2500) begin
      n_bad++;
      $display("[TB] FAIL prereset_stream got=(%0d,v%b) exp=(2500,v1)", oi_h[cyc-1], ov_h[cyc-1]);
    end
    in_valid = 1'b0;
    sig_in_i = '0;
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if (sig_out_i !== 20'd0 || sig_out_q !== 20'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL async_reset got=(%0d,%0d,v%b) exp=(0,0,v0)", sig_out_i, sig_out_q, out_valid);
    end
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    t0 = cyc;
    idle(LAT + 4);
    for (int i = 0; i < LAT + 4; i++) begin
      n_cmp++;
      if (ov_h[t0+i] !== 1'b0) begin
        n_bad++;
        $display("[TB] FAIL stale_valid[%0d] got=%b exp=0", i, ov_h[t0+i]);
      end
    end
    t1 = cyc;
    step(7000, -3000, 1'b1, 1'b0, 524287, 0);
    idle(LAT + 1);
    n_cmp++;
    if (oi_h[t1+LAT] !== 7000 || oq_h[t1+LAT] !== -3000 || ov_h[t1+LAT] !== 1'b1 ||
        ov_h[t1+LAT-1] !== 1'b0 || sf_h[t1+LAT] !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL post_reset got=(%0d,%0d,v%b,pre%b,s%b) exp=(7000,-3000,v1,pre0,s0)",
               oi_h[t1+LAT], oq_h[t1+LAT], ov_h[t1+LAT], ov_h[t1+LAT-1], sf_h[t1+LAT]);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    sig_in_i = '0; sig_in_q = '0; in_valid = 1'b0;
    mag_0 = '0; mag_1 = '0; mag_2 = '0; mag_3 = '0; mag_4 = '0;
    coef_wr = 1'b0; coef_addr = '0; coef_re = '0; coef_im = '0;
    coef_commit = 1'b0; bypass = 1'b0; sat_clr = 1'b0;
    cyc = 0; n_cmp = 0; n_bad = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_coef_swap();
    test_write_commit();
    test_saturation();
    test_bypass_toggle();
    test_s2_clip();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
